// File: rtl/fetch_unit.sv
// Instruction fetch front end for the 8-bit CPU: fetches 16-bit little-endian
// instructions over the shared byte bus and dispatches them to the ALU or LSU.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic        alu_en,
    output logic        lsu_en,
    input  logic        lsu_done,
    output logic        halted,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        CAPTURE,
        DECODE,
        WAIT_LSU,
        HALT
    } state_t;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;

    assign opcode = instruction[15:12];
    assign mem_we = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_addr   = 16'h0000;
        case (state)
            IDLE:     state_next = FETCH_LO;
            FETCH_LO: begin
                mem_en     = 1'b1;
                mem_addr   = pc;
                state_next = FETCH_HI;
            end
            FETCH_HI: begin
                mem_en     = 1'b1;
                mem_addr   = pc + 16'd1;
                state_next = CAPTURE;
            end
            CAPTURE:  state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_HALT:      state_next = HALT;
                    OP_LD, OP_ST: state_next = WAIT_LSU;
                    default:      state_next = FETCH_LO;
                endcase
            end
            WAIT_LSU: if (lsu_done) state_next = FETCH_LO;
            HALT:     state_next = HALT;
            default:  state_next = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so each byte lands one state later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= 16'h0000;
            instr_valid <= 1'b0;
            alu_en      <= 1'b0;
            lsu_en      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            alu_en <= 1'b0;
            case (state)
                FETCH_LO: instr_valid <= 1'b0;
                FETCH_HI: instruction[7:0] <= mem_rdata;
                CAPTURE: begin
                    instruction[15:8] <= mem_rdata;
                    pc                <= pc + 16'd2;
                    instr_valid       <= 1'b1;
                end
                DECODE: begin
                    case (opcode)
                        OP_HALT: halted <= 1'b1;
                        OP_JMP: begin
                            // Jump stays within the page of the already-advanced pc.
                            pc          <= {pc[15:12], instruction[11:0]};
                            instr_valid <= 1'b0;
                        end
                        OP_LD, OP_ST: lsu_en <= 1'b1;
                        default: begin
                            alu_en      <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    endcase
                end
                WAIT_LSU: begin
                    if (lsu_done) begin
                        lsu_en      <= 1'b0;
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte-memory models feed two instances
// (RESET_PC 0x0000 and 0xFFFE); expected fetch addresses go through queues.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [7:0]  mem_rdata0, mem_rdata1;
    logic [15:0] mem_addr0, mem_addr1;
    logic        mem_en0, mem_en1, mem_we0, mem_we1;
    logic [15:0] instruction0, instruction1;
    logic        instr_valid0, instr_valid1;
    logic        alu_en0, alu_en1, lsu_en0, lsu_en1;
    logic        lsu_done0, lsu_done1;
    logic        halted0, halted1;
    logic [15:0] pc0, pc1;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst(rst0), .mem_rdata(mem_rdata0), .mem_addr(mem_addr0),
        .mem_en(mem_en0), .mem_we(mem_we0), .instruction(instruction0),
        .instr_valid(instr_valid0), .alu_en(alu_en0), .lsu_en(lsu_en0),
        .lsu_done(lsu_done0), .halted(halted0), .pc(pc0)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
        .clk(clk), .rst(rst1), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
        .mem_en(mem_en1), .mem_we(mem_we1), .instruction(instruction1),
        .instr_valid(instr_valid1), .alu_en(alu_en1), .lsu_en(lsu_en1),
        .lsu_done(lsu_done1), .halted(halted1), .pc(pc1)
    );

    // Synchronous-read memories: data appears the cycle after the request.
    always @(posedge clk) begin
        mem_rdata0 <= mem_en0 ? mem0[mem_addr0] : 8'h00;
        mem_rdata1 <= mem_en1 ? mem1[mem_addr1] : 8'h00;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score any fetch request against the queues.
    task automatic step();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (mem_en0) begin
            check("fetch0_expected", 16'(q0.size() != 0), 16'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("fetch0_addr", mem_addr0, e);
            end
        end
        if (mem_en1) begin
            check("fetch1_expected", 16'(q1.size() != 0), 16'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("fetch1_addr", mem_addr1, e);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        lsu_done0 = 1'b0;
        lsu_done1 = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 8'h00;
            mem1[a] = 8'h00;
        end
        mem0[16'h0000] = 8'h34; mem0[16'h0001] = 8'h52;  // ALU 5234
        mem0[16'h0002] = 8'h00; mem0[16'h0003] = 8'h1C;  // LD 1C00
        mem0[16'h0004] = 8'h10; mem0[16'h0005] = 8'hF0;  // JMP F010
        mem0[16'h0010] = 8'h23; mem0[16'h0011] = 8'hF1;  // JMP F123
        mem1[16'hFFFE] = 8'h00; mem1[16'hFFFF] = 8'h30;  // ALU 3000

        repeat (2) @(negedge clk);
        check("rst_pc", pc0, 16'h0000);
        check("rst_ir", instruction0, 16'h0000);
        check("rst_valid", 16'(instr_valid0), 16'd0);
        check("rst_alu_en", 16'(alu_en0), 16'd0);
        check("rst_lsu_en", 16'(lsu_en0), 16'd0);
        check("rst_halted", 16'(halted0), 16'd0);
        check("rst_mem_en", 16'(mem_en0), 16'd0);
        check("rst_mem_addr", mem_addr0, 16'h0000);
        check("rst_mem_we", 16'(mem_we0), 16'd0);
        check("rst_pc1", pc1, 16'hFFFE);

        q0.push_back(16'h0000); q0.push_back(16'h0001);
        q0.push_back(16'h0002); q0.push_back(16'h0003);
        q0.push_back(16'h0004); q0.push_back(16'h0005);
        q0.push_back(16'h0010); q0.push_back(16'h0011);
        q0.push_back(16'h0123); q0.push_back(16'h0124);

        // lsu_done held high outside WAIT_LSU must have no effect.
        @(negedge clk);
        rst0 = 1'b0;
        lsu_done0 = 1'b1;
        step();                                   // FETCH_LO @0000
        check("lo_mem_en", 16'(mem_en0), 16'd1);
        step();                                   // FETCH_HI @0001
        check("hi_valid", 16'(instr_valid0), 16'd0);
        step();                                   // CAPTURE
        check("cap_mem_en", 16'(mem_en0), 16'd0);
        check("cap_mem_addr", mem_addr0, 16'h0000);
        step();                                   // DECODE
        check("alu_ir", instruction0, 16'h5234);
        check("alu_valid", 16'(instr_valid0), 16'd1);
        check("alu_pc", pc0, 16'h0002);
        check("alu_en_early", 16'(alu_en0), 16'd0);
        lsu_done0 = 1'b0;
        step();                                   // FETCH_LO @0002
        check("alu_en_pulse", 16'(alu_en0), 16'd1);
        check("alu_lsu_en", 16'(lsu_en0), 16'd0);
        step();
        check("alu_en_drop", 16'(alu_en0), 16'd0);
        steps(2);                                 // CAPTURE, DECODE
        check("ld_ir", instruction0, 16'h1C00);

        for (int i = 0; i < 3; i++) begin         // three WAIT_LSU cycles
            step();
            check("ld_lsu_en", 16'(lsu_en0), 16'd1);
            check("ld_mem_en", 16'(mem_en0), 16'd0);
            check("ld_ir_hold", instruction0, 16'h1C00);
            check("ld_alu_en", 16'(alu_en0), 16'd0);
        end
        lsu_done0 = 1'b1;
        step();                                   // FETCH_LO @0004
        lsu_done0 = 1'b0;
        check("ld_lsu_drop", 16'(lsu_en0), 16'd0);
        check("ld_resume_pc", pc0, 16'h0004);
        check("ld_resume_en", 16'(mem_en0), 16'd1);

        steps(3);
        check("jmp1_ir", instruction0, 16'hF010);
        check("jmp1_pc", pc0, 16'h0006);
        step();                                   // FETCH_LO @0010
        check("jmp1_target", pc0, 16'h0010);
        check("jmp1_alu_en", 16'(alu_en0), 16'd0);
        check("jmp1_lsu_en", 16'(lsu_en0), 16'd0);
        steps(3);
        check("jmp2_ir", instruction0, 16'hF123);
        check("jmp2_pc", pc0, 16'h0012);
        step();                                   // FETCH_LO @0123
        check("jmp2_target", pc0, 16'h0123);
        check("jmp2_alu_en", 16'(alu_en0), 16'd0);
        check("jmp2_lsu_en", 16'(lsu_en0), 16'd0);
        steps(3);
        check("halt_ir", instruction0, 16'h0000);
        step();
        check("halt_flag", 16'(halted0), 16'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_hold", 16'(halted0), 16'd1);
            check("halt_mem_en", 16'(mem_en0), 16'd0);
        end
        check("q0_drained", 16'(q0.size()), 16'd0);

        @(negedge clk);
        rst0 = 1'b1;
        #1;
        check("rehalt_flag", 16'(halted0), 16'd0);
        check("rehalt_pc", pc0, 16'h0000);
        q0.push_back(16'h0000); q0.push_back(16'h0001);
        q0.push_back(16'h0002); q0.push_back(16'h0003);
        @(negedge clk);
        rst0 = 1'b0;
        steps(9);                                 // into WAIT_LSU on the LD
        check("mid_lsu_en", 16'(lsu_en0), 16'd1);
        #2;
        rst0 = 1'b1;
        #1;
        check("async_lsu_en", 16'(lsu_en0), 16'd0);
        check("async_valid", 16'(instr_valid0), 16'd0);
        check("async_pc", pc0, 16'h0000);
        check("async_ir", instruction0, 16'h0000);
        check("async_mem_en", 16'(mem_en0), 16'd0);
        check("q0_drained2", 16'(q0.size()), 16'd0);

        q1.push_back(16'hFFFE); q1.push_back(16'hFFFF);
        q1.push_back(16'h0000); q1.push_back(16'h0001);
        @(negedge clk);
        rst1 = 1'b0;
        steps(4);                                 // through DECODE
        check("wrap_ir", instruction1, 16'h3000);
        check("wrap_pc", pc1, 16'h0000);
        step();                                   // FETCH_LO @0000
        check("wrap_alu_en", 16'(alu_en1), 16'd1);
        steps(4);
        check("wrap_halted", 16'(halted1), 16'd1);
        check("q1_drained", 16'(q1.size()), 16'd0);
        check("mem_we1", 16'(mem_we1), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the 8-bit CPU.
- Fetches 16-bit little-endian instructions over the shared 8-bit memory bus, holds the PC, and presents the decoded instruction to the backend.
- Dispatches load/store instructions to the LSU with an lsu_en/lsu_done handshake, and releases the memory bus to the LSU while it runs.
- Also handles HALT, JMP, and single-cycle ALU dispatch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- mem_rdata  input  8  read data from memory; valid one cycle after mem_addr/mem_en are presented.
- mem_addr  output  16  fetch address; 16'h0000 when mem_en=0.
- mem_en  output  1  fetch unit owns bus and requests a read.
- mem_we  output  1  constant 0; the fetch unit never writes.
- instruction  output  16  current instruction register (IR) to the backend/LSU.
- instr_valid  output  1  IR holds a fully fetched instruction.
- alu_en  output  1  one-cycle pulse dispatching a non-memory instruction.
- lsu_en  output  1  LSU request; held until lsu_done.
- lsu_done  input  1  LSU completion.
- halted  output  1  core halted.
- pc  output  16  address of the next instruction to fetch.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=RESET_PC, IR=16'h0000.
  - instr_valid=0, alu_en=0, lsu_en=0, halted=0, mem_en=0, mem_addr=0.
- Encoding: opcode=IR[15:12]; low byte stored at pc, high byte at pc+1.
- mem_en/mem_addr are a combinational decode of state and pc. All other outputs are registered.
- States and per-cycle actions:
  - IDLE: entered only from reset; first posedge after rst deasserts -> FETCH_LO.
  - FETCH_LO: mem_en=1, mem_addr=pc; instr_valid<=0 -> FETCH_HI.
  - FETCH_HI: mem_en=1, mem_addr=pc+1 (16-bit wrap, 16'hFFFF+1=16'h0000); IR[7:0]<=mem_rdata -> CAPTURE.
  - CAPTURE: mem_en=0; IR[15:8]<=mem_rdata; pc<=pc+2 (mod 2^16); instr_valid<=1 -> DECODE.
  - DECODE (one cycle; instruction stable), by opcode:
    - 4'b0000 HALT: halted<=1 -> HALT.
    - 4'b1111 JMP: pc<={pc[15:12], IR[11:0]}, using the already-incremented pc page -> FETCH_LO.
    - 4'b0001 LD / 4'b0010 ST: lsu_en<=1 -> WAIT_LSU.
    - any other opcode: alu_en<=1 for exactly one cycle -> FETCH_LO.
  - WAIT_LSU:
    - mem_en=0 (bus released to LSU); IR and instr_valid held.
    - On a posedge with lsu_done=1: lsu_en<=0 -> FETCH_LO. Minimum one WAIT_LSU cycle.
  - HALT: mem_en=0, all enables 0, halted=1. Exit only via rst.
- lsu_done is ignored outside WAIT_LSU.
- alu_en and lsu_en are never both 1.
- Latency: ALU instruction = 4 cycles fetch-to-next-fetch. LD/ST = 4 + LSU cycles.
- instruction output holds its value from DECODE until overwritten in FETCH_HI/CAPTURE of the next fetch. instr_valid is low from FETCH_LO through CAPTURE.
- Reset asserted in any state, including WAIT_LSU with lsu_en=1, immediately forces the reset values; no LSU handshake completion is required.
- mem_we=0 at all times, including reset.

Test Plan:
- Reset release, memory 0x0000=0x34, 0x0001=0x52 (ALU opcode 5):
  - mem_addr 0x0000 then 0x0001 on consecutive cycles.
  - instruction=16'h5234 with instr_valid=1 in DECODE.
  - alu_en one-cycle pulse; pc=0x0002; next mem_addr=0x0002.
- LD 16'h1C00 at 0x0002, lsu_done asserted 3 cycles after lsu_en rises:
  - lsu_en stays high exactly 3 cycles; mem_en=0 throughout; instruction=16'h1C00 stable.
  - Fetch resumes at 0x0004 the cycle after lsu_done is sampled.
- JMP 16'hF123 fetched at 0x0010 -> next fetch mem_addr=0x0123; alu_en and lsu_en stay 0.
- RESET_PC=16'hFFFE, instruction 16'h3000:
  - Fetch addresses 0xFFFE, 0xFFFF.
  - pc wraps to 0x0000 and the next fetch is at 0x0000.
- HALT 16'h0000 -> halted=1, mem_en=0 for 20 cycles, no further fetches; rst pulse -> halted=0, fetch restarts at RESET_PC.
- rst asserted mid-WAIT_LSU (lsu_en=1) -> lsu_en=0, instr_valid=0, pc=RESET_PC asynchronously, before the next clk edge.
